serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial ripple-borrow subtractor: computes diff = a - b - bin one bit per clock, LSB first,
//  through a single full-subtractor cell and a borrow flop. Companion to the combinational
//  ripple-carry adder: the same ripple, run in the other direction (borrow instead of carry),
//  and in time rather than in space. Sits between a requesting datapath and a result consumer,
//  with valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands a, b, bin present
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      diff/bout valid, held until accepted
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//  bout       out  1      borrow out: 1 iff a < b + bin (unsigned)
//  ovf        out  1      signed overflow (SERIAL_SUB_OVF_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0,
//    shift regs, borrow flop and bit counter cleared. Reset mid-operation aborts; no result emitted.
//  - FSM: IDLE -> SHIFT on (in_valid & in_ready); SHIFT -> DONE after WIDTH bit-cycles;
//    DONE -> IDLE on out_ready. No other transitions.
//  - IDLE: in_ready=1. On acceptance edge: load a, b into shift regs, borrow flop <= bin, cnt <= 0.
//  - SHIFT: in_ready=0. Each edge: d = a0^b0^br; br <= (~a0&b0)|(~(a0^b0)&br); d shifted into diff
//    MSB-side so diff is LSB-aligned after WIDTH shifts; cnt++. Last shift (cnt==WIDTH-1): bout <= new br.
//  - Latency: out_valid rises after exactly WIDTH+1 rising edges, counting the acceptance edge.
//  - DONE: out_valid=1, diff/bout/ovf stable; in_ready=0. Handshake completes on edge where
//    out_valid & out_ready; out_valid drops next cycle; diff/bout hold last value until the next result.
//  - in_valid while busy (SHIFT/DONE) is ignored; operands are not captured. Producer must hold.
//  - out_ready while not DONE has no effect. out_ready held high: DONE lasts exactly one cycle.
//  - Back-to-back: next operands accepted no earlier than the cycle after DONE->IDLE (no overlap).
//  - Arithmetic: unsigned modulo 2^WIDTH; bin=1 with a==b yields all-ones diff, bout=1.
//  - a, b, bin sampled only at acceptance; later changes do not affect an in-flight result.
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined: ovf computed at last shift = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB])
//    (two's-complement overflow), updated with diff/bout, held like them; reset 0.
//  SERIAL_SUB_OVF_EN undefined: ovf port present, driven constant 0; no sign-capture logic.
// TESTING  (WIDTH=4; each case: accept, wait out_valid, check, pulse out_ready)
//  a=0001 b=1000 bin=0 -> diff=1001 bout=1; out_valid exactly 5 edges after acceptance edge
//  a=1100 b=0011 bin=0 -> diff=1001 bout=0; a=1111 b=1111 bin=0 -> diff=0000 bout=0
//  a=0000 b=0000 bin=1 -> diff=1111 bout=1 (borrow ripples through all bits)
//  a=0111 b=1000 bin=0 -> diff=1111 bout=1; ovf=1 with SERIAL_SUB_OVF_EN, ovf=0 without
//  in_valid pulsed mid-SHIFT with a=1111 -> ignored, result of first op unchanged; out_ready held
//    low 10 cycles -> out_valid, diff stay stable throughout
//  rst_n low during SHIFT cycle 2 -> immediately out_valid=0, in_ready=1, diff=0; next op correct

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             br, br_nxt, d;
  logic [CW-1:0]    cnt;
  logic             accept, last;

  // Full-subtractor cell on the current LSBs
  assign d      = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign accept = in_valid & in_ready;
  assign last   = (state == SHIFT) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // diff/bout are only written on the last shift so they hold the previous result meanwhile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      br   <= bin;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      br     <= br_nxt;
      res_sh <= {d, res_sh[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
      if (last) begin
        diff <= {d, res_sh[WIDTH-1:1]};
        bout <= br_nxt;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // On the last shift the cell sees the operand sign bits and d is the result sign bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (last) ovf <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d);
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;

  logic       clk, rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] a, b, diff;
  logic       bin, bout, ovf;
  int         total, bad;

`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Accept one operation, measure latency, check result, then pulse out_ready
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                        input logic [3:0] ed, input logic eb, input logic eo, input string nm);
    int edges;
    bit seen;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb_v; bin = tbin;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s in_ready before accept got=%b exp=1", nm, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
    edges = 1; seen = 0;
    while (!seen && edges < 20) begin
      if (out_valid === 1'b1) seen = 1;
      else begin @(posedge clk); #1; edges++; end
    end
    total++;
    if (edges !== 5) begin bad++; $display("FAIL %s latency got=%0d exp=5", nm, edges); end
    total++;
    if (diff !== ed) begin bad++; $display("FAIL %s diff got=%b exp=%b", nm, diff, ed); end
    total++;
    if (bout !== eb) begin bad++; $display("FAIL %s bout got=%b exp=%b", nm, bout, eb); end
    total++;
    if (ovf !== (eo & OVF_ON)) begin bad++; $display("FAIL %s ovf got=%b exp=%b", nm, ovf, eo & OVF_ON); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL %s in_ready in done got=%b exp=0", nm, in_ready); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s after handshake out_valid=%b in_ready=%b exp 0/1", nm, out_valid, in_ready);
    end
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 4'b0 || bout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset got in_ready=%b out_valid=%b diff=%b bout=%b ovf=%b exp 1 0 0000 0 0",
               in_ready, out_valid, diff, bout, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_arith();
    run_op(4'b0001, 4'b1000, 1'b0, 4'b1001, 1'b1, 1'b1, "a1_b8");
    run_op(4'b1100, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b0, "a12_b3");
    run_op(4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, "a15_b15");
    run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, "zero_bin");
    run_op(4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1, "a7_b8");
    run_op(4'b0101, 4'b0101, 1'b1, 4'b1111, 1'b1, 1'b0, "eq_bin");
  endtask

  task automatic test_busy_stall();
    int n;
    @(negedge clk);
    in_valid = 1'b1; a = 4'b0011; b = 4'b0001; bin = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b1; a = 4'b1111; b = 4'b0000; bin = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL busy in_ready got=%b exp=0", in_ready); end
    @(negedge clk); in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL busy timeout out_valid got=%b exp=1", out_valid); end
    total++;
    if (diff !== 4'b0010 || bout !== 1'b0) begin
      bad++; $display("FAIL busy result diff=%b bout=%b exp 0010 0", diff, bout);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || diff !== 4'b0010) begin
        bad++; $display("FAIL stall cycle %0d out_valid=%b diff=%b exp 1 0010", i, out_valid, diff);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); out_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL busy ignored op out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_hold_ready();
    int hi, n;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 4'b1010; b = 4'b0011; bin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (diff !== 4'b0110 || bout !== 1'b0 || ovf !== OVF_ON) begin
      bad++; $display("FAIL hold_ready result diff=%b bout=%b ovf=%b exp 0110 0 %b", diff, bout, ovf, OVF_ON);
    end
    hi = 0;
    while (out_valid === 1'b1 && hi < 20) begin hi++; @(posedge clk); #1; end
    total++;
    if (hi !== 1) begin bad++; $display("FAIL hold_ready done cycles got=%0d exp=1", hi); end
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; a = 4'b1001; b = 4'b0100; bin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 4'b0000) begin
      bad++; $display("FAIL reset_mid out_valid=%b in_ready=%b diff=%b exp 0 1 0000", out_valid, in_ready, diff);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_mid aborted result out_valid=%b exp=0", out_valid); end
    run_op(4'b0101, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_arith();
    test_busy_stall();
    test_hold_ready();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout got=expired exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
